// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: fetch address split, instruction-cache frame
// layout and the instruction-cache controller states.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int IBYT_W = 2;
    localparam int IIDX_W = 4;
    localparam int ITAG_W = WORD_W - IIDX_W - IBYT_W;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [IBYT_W-1:0] bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Frame storage for the instruction cache: one write port, one combinational
// read port and a single-cycle bulk clear of every valid bit.
module icache_array
    import cpu_types_pkg::*;
#(
    parameter int NSETS = 16
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              flush,
    input  logic              wen,
    input  logic [IIDX_W-1:0] widx,
    input  icache_frame       wframe,
    input  logic [IIDX_W-1:0] ridx,
    output icache_frame       rframe
);

    logic [NSETS-1:0]  valid_reg;
    logic [ITAG_W-1:0] tag_mem  [NSETS];
    word_t             data_mem [NSETS];

    // Flush outranks a simultaneous fill, so a frame filled on the flush
    // edge lands with its valid bit cleared.
    genvar gi;
    generate
        for (gi = 0; gi < NSETS; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (srst || flush) begin
                    valid_reg[gi] <= 1'b0;
                end else if (wen && (widx == IIDX_W'(gi))) begin
                    valid_reg[gi] <= wframe.valid;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wen) begin
            tag_mem[widx]  <= wframe.tag;
            data_mem[widx] <= wframe.data;
        end
    end

    always_comb begin
        rframe       = '0;
        rframe.valid = valid_reg[ridx];
        rframe.tag   = tag_mem[ridx];
        rframe.data  = data_mem[ridx];
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, single-word
// blocking refill from memory, whole-cache invalidate.
module icache
    import cpu_types_pkg::*;
#(
    parameter int NSETS = 16
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    input  logic  iflush,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload
);

    icache_state_t     state_reg;
    logic [ITAG_W-1:0] miss_tag_reg;
    logic [IIDX_W-1:0] miss_idx_reg;
    logic              iren_reg;
    word_t             iaddr_reg;

    icachef_t    req;
    icache_frame rd_frame;
    icache_frame fill_frame;
    logic        hit;
    logic        fill_en;
    logic        unused_bytoff;

    assign req           = icachef_t'(imemaddr);
    assign unused_bytoff = ^req.bytoff;

    assign hit     = rd_frame.valid && (rd_frame.tag == req.tag);
    assign fill_en = (state_reg == MISS) && !iwait;

    always_comb begin
        fill_frame       = '0;
        fill_frame.valid = 1'b1;
        fill_frame.tag   = miss_tag_reg;
        fill_frame.data  = iload;
    end

    icache_array #(
        .NSETS(NSETS)
    ) u_array (
        .clk    (CLK),
        .srst   (RST),
        .flush  (iflush),
        .wen    (fill_en),
        .widx   (miss_idx_reg),
        .wframe (fill_frame),
        .ridx   (req.idx),
        .rframe (rd_frame)
    );

    // A flush in the lookup cycle suppresses the hit, since the frame is
    // being invalidated on the same edge.
    assign ihit     = (state_reg == IDLE) && imemREN && hit && !iflush;
    assign imemload = ihit ? rd_frame.data : '0;
    assign iREN     = iren_reg;
    assign iaddr    = iaddr_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            miss_tag_reg <= '0;
            miss_idx_reg <= '0;
            iren_reg     <= 1'b0;
            iaddr_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (imemREN && !hit && !iflush) begin
                        state_reg    <= MISS;
                        miss_tag_reg <= req.tag;
                        miss_idx_reg <= req.idx;
                        iren_reg     <= 1'b1;
                        iaddr_reg    <= {req.tag, req.idx, 2'b00};
                    end
                end
                MISS: begin
                    // The refill always completes so memory never sees an
                    // abandoned transaction; a flush only clears valid bits.
                    if (!iwait) begin
                        state_reg <= IDLE;
                        iren_reg  <= 1'b0;
                        iaddr_reg <= '0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    iren_reg  <= 1'b0;
                    iaddr_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus queues expected hit data and memory
// request addresses; a monitor pops and compares whenever the DUT presents them.
module tb_icache;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  RST;
    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iflush;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    int checks   = 0;
    int failures = 0;

    word_t hit_q[$];
    word_t req_q[$];

    icache #(.NSETS(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iflush   (iflush),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input word_t act, input word_t req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: samples on the falling edge, away from input changes.
    logic  prev_iren  = 1'b0;
    word_t prev_iaddr = '0;
    always @(negedge CLK) begin
        if (!RST) begin
            if (ihit) begin
                if (hit_q.size() == 0) begin
                    check("unexpected_hit", {31'd0, ihit}, 32'd0);
                end else begin
                    word_t exp_data;
                    exp_data = hit_q.pop_front();
                    check("hit_data", imemload, exp_data);
                    $display("hit  addr=0x%08h data=0x%08h", imemaddr, imemload);
                end
            end else if (!iREN) begin
                check("idle_load_zero", imemload, 32'd0);
            end
            if (iREN && !prev_iren) begin
                if (req_q.size() == 0) begin
                    check("unexpected_iREN", {31'd0, iREN}, 32'd0);
                end else begin
                    word_t exp_addr;
                    exp_addr = req_q.pop_front();
                    check("miss_iaddr", iaddr, exp_addr);
                    $display("miss iaddr=0x%08h", iaddr);
                end
            end else if (iREN && prev_iren) begin
                check("iaddr_stable", iaddr, prev_iaddr);
            end else if (!iREN) begin
                check("idle_iaddr_zero", iaddr, 32'd0);
            end
        end
        prev_iren  <= RST ? 1'b0 : iREN;
        prev_iaddr <= iaddr;
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic read_hit(input word_t addr, input word_t data);
        imemREN  = 1'b1;
        imemaddr = addr;
        hit_q.push_back(data);
        cyc();
        imemREN = 1'b0;
    endtask

    // Miss with nwait busy cycles; optional flush on the fill cycle and an
    // optional address wander while the refill is outstanding.
    task automatic read_miss(input word_t addr, input int nwait, input word_t load,
                             input logic flush_at_fill, input word_t wander_addr);
        imemREN  = 1'b1;
        imemaddr = addr;
        req_q.push_back({addr[31:2], 2'b00});
        cyc();
        if (wander_addr != 0) imemaddr = wander_addr;
        iwait = 1'b1;
        for (int i = 0; i < nwait; i++) cyc();
        iwait  = 1'b0;
        iload  = load;
        iflush = flush_at_fill;
        cyc();
        iwait    = 1'b1;
        iload    = '0;
        iflush   = 1'b0;
        imemaddr = addr;
        if (!flush_at_fill) begin
            hit_q.push_back(load);
            cyc();
        end
        imemREN = 1'b0;
    endtask

    initial begin
        RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iflush = 1'b0;
        iwait = 1'b1; iload = '0;
        cyc(); cyc();
        @(negedge CLK);
        check("rst_ihit", {31'd0, ihit}, 32'd0);
        check("rst_imemload", imemload, 32'd0);
        check("rst_iREN", {31'd0, iREN}, 32'd0);
        check("rst_iaddr", iaddr, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        cyc();

        read_miss(32'h0000_0044, 3, 32'h2001_000A, 1'b0, 32'd0);
        read_hit(32'h0000_0044, 32'h2001_000A);
        read_hit(32'h0000_0046, 32'h2001_000A);
        cyc();

        // Same index, different tag: each fill evicts the other.
        read_miss(32'h0000_0084, 0, 32'h8C22_0000, 1'b0, 32'd0);
        read_miss(32'h0000_0044, 1, 32'h2001_000A, 1'b0, 32'd0);
        read_miss(32'h0000_0084, 0, 32'h8C22_0000, 1'b0, 32'd0);
        read_hit(32'h0000_0084, 32'h8C22_0000);

        // Flush in IDLE with a pending lookup: no hit, then miss.
        imemREN = 1'b1; imemaddr = 32'h0000_0084; iflush = 1'b1;
        cyc();
        iflush = 1'b0; imemREN = 1'b0;
        read_miss(32'h0000_0084, 2, 32'h8C22_0000, 1'b0, 32'd0);

        // Flush coincident with fill: frame lands invalid.
        read_miss(32'h0000_0200, 1, 32'hDEAD_BEEF, 1'b1, 32'd0);
        read_miss(32'h0000_0200, 0, 32'hDEAD_BEEF, 1'b0, 32'd0);

        // Address wanders during MISS: fill still targets the latched address.
        read_miss(32'h0000_0308, 2, 32'h1234_5678, 1'b0, 32'h0000_0044);
        read_hit(32'h0000_0308, 32'h1234_5678);
        read_hit(32'h0000_0200, 32'hDEAD_BEEF);

        // Reset during MISS drops the refill and every line.
        imemREN = 1'b1; imemaddr = 32'h0000_0100;
        req_q.push_back(32'h0000_0100);
        cyc();
        imemREN = 1'b0; iwait = 1'b1;
        cyc();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        @(negedge CLK);
        check("rst_miss_iREN", {31'd0, iREN}, 32'd0);
        check("rst_miss_ihit", {31'd0, ihit}, 32'd0);
        @(posedge CLK); #1;
        read_miss(32'h0000_0308, 0, 32'h1234_5678, 1'b0, 32'd0);
        read_miss(32'h0000_0200, 1, 32'hDEAD_BEEF, 1'b0, 32'd0);
        read_miss(32'h0000_0084, 0, 32'h8C22_0000, 1'b0, 32'd0);

        cyc(); cyc();
        check("hit_q_drained", hit_q.size(), 32'd0);
        check("req_q_drained", req_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
